// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared definitions for the UART/ALU sequencer, the ALU and the testbench.
//   state_e      - 3-bit sequencer state encoding
//   BYTE_W, OP_W - UART byte width and ALU opcode width
//   OP_*         - ALU opcode values
package uart_alu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StCompute = 3'd3,
    StSend   = 3'd4,
    StWaitTx = 3'd5
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD    = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB    = 6'h22;
  localparam logic [OP_W-1:0] OP_AND    = 6'h24;
  localparam logic [OP_W-1:0] OP_OR     = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR    = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR    = 6'h27;
  localparam logic [OP_W-1:0] OP_SRA    = 6'h03;
  localparam logic [OP_W-1:0] OP_SRL    = 6'h02;
  localparam logic [OP_W-1:0] OP_PASS_A = 6'h00;
  localparam logic [OP_W-1:0] OP_PASS_B = 6'h01;

endpackage

// File: rtl/uart_alu_interface_frame_gap_timer.sv
// frame_gap_timer: inter-byte gap counter for the UART/ALU sequencer.
//   clk     - clock
//   reset   - synchronous active-high reset
//   run     - sequencer is waiting for a further byte of the frame
//   clear   - a byte was accepted this cycle
//   expired - gap has reached TIMEOUT_CYCLES - 1 cycles while running
module frame_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    // Held at zero outside the waiting states and restarted on every accepted byte.
    if (!run || clear || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: sequencer between UART receiver, ALU and UART transmitter.
// Collects a frame {A, B, opcode}, drives the ALU, captures the result and transmits it.
// Optional feature: define IFACE_TIMEOUT_EN to abort a frame whose inter-byte gap
// reaches TIMEOUT_CYCLES - 1 cycles.
//   clk, reset          - clock, synchronous active-high reset
//   rx_done_tick/rx_data - received byte strobe and data
//   tx_done_tick        - transmitter finished
//   alu_result          - combinational ALU result
//   alu_a/alu_b/alu_op  - registered ALU inputs
//   tx_start/tx_data    - transmit request pulse and sign-extended result byte
//   busy                - high whenever not idle
import uart_alu_pkg::*;

module uart_alu_interface #(
  parameter int unsigned size           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              tx_done_tick,
  input  logic [size-1:0]   alu_result,
  output logic [size-1:0]   alu_a,
  output logic [size-1:0]   alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [size-1:0]   alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic [BYTE_W-1:0] res_pad, res_ext;
  logic              gap_expired;

`ifdef IFACE_TIMEOUT_EN
  frame_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .run    ((state_q == StWaitB) || (state_q == StWaitOp)),
    .clear  (rx_done_tick),
    .expired(gap_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign gap_expired    = 1'b0;
`endif

  // Sign-extend from bit size-1; zero-padding first keeps every index in range for size = 8.
  always_comb begin
    res_pad = BYTE_W'(alu_result);
    res_ext = '0;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      res_ext[i] = (i < int'(size)) ? res_pad[i] : res_pad[size-1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (rx_done_tick) state_d = StWaitB;
      StWaitB: begin
        if (rx_done_tick)     state_d = StWaitOp;
        else if (gap_expired) state_d = StIdle;
      end
      StWaitOp: begin
        if (rx_done_tick)     state_d = StCompute;
        else if (gap_expired) state_d = StIdle;
      end
      StCompute: state_d = StSend;
      StSend:    state_d = StWaitTx;
      StWaitTx:  if (tx_done_tick) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && rx_done_tick)   alu_a_q   <= rx_data[size-1:0];
      if (state_q == StWaitB && rx_done_tick)  alu_b_q   <= rx_data[size-1:0];
      if (state_q == StWaitOp && rx_done_tick) alu_op_q  <= rx_data[OP_W-1:0];
      if (state_q == StCompute)                tx_data_q <= res_ext;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == StSend);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_alu_interface.sv
import uart_alu_pkg::*;

module tb_uart_alu_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;

  uart_alu_interface #(
    .size          (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .tx_done_tick(tx_done_tick),
    .alu_result  (alu_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU driving the DUT's result input.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_NOR:    return ~(a | b);
      OP_SRA:    return 8'($signed(a) >>> b[2:0]);
      OP_SRL:    return a >> b[2:0];
      OP_PASS_A: return a;
      OP_PASS_B: return b;
      default:   return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

  always @(posedge clk) if (tx_start) tx_cnt <= tx_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Tick is raised at a negedge, sampled by one posedge, dropped at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  // Full frame; ends in WAIT_TX with every stage of the latency checked.
  task automatic run_frame(input vec_t v);
    int start_cnt;
    start_cnt = tx_cnt;
    send_byte(v.a);
    send_byte(v.b);
    send_byte(v.op);
    check("tx_start low in COMPUTE", 32'(tx_start), 32'd0);
    check("busy in COMPUTE", 32'(busy), 32'd1);
    @(negedge clk);
    check("tx_start in SEND", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(v.exp_tx));
    check("alu_op", 32'(alu_op), 32'(v.exp_op));
    check("alu_a", 32'(alu_a), 32'(v.a));
    check("alu_b", 32'(alu_b), 32'(v.b));
    @(negedge clk);
    check("tx_start low in WAIT_TX", 32'(tx_start), 32'd0);
    check("busy in WAIT_TX", 32'(busy), 32'd1);
    check("tx_start count", 32'(tx_cnt - start_cnt), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    int c0;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE};
    vecs[2] = '{8'h80, 8'h02, 8'h03, 6'h03, 8'hE0};
    vecs[3] = '{8'h09, 8'h04, 8'hE2, 6'h22, 8'h05};
    vecs[4] = '{8'hF0, 8'h0F, 8'h27, 6'h27, 8'h00};
    vecs[5] = '{8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08};
    vecs[6] = '{8'h0C, 8'h0A, 8'h66, 6'h26, 8'h06};

    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset alu_a", 32'(alu_a), 32'd0);
    check("reset alu_b", 32'(alu_b), 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;

    // tx_done outside WAIT_TX is ignored.
    pulse_tx_done();
    check("tx_done ignored in IDLE", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
      pulse_tx_done();
      check("idle after tx_done", 32'(busy), 32'd0);
    end

    // Byte during WAIT_TX is dropped.
    run_frame(vecs[3]);
    send_byte(8'h7F);
    check("drop in WAIT_TX busy", 32'(busy), 32'd1);
    pulse_tx_done();
    check("drop in WAIT_TX alu_a", 32'(alu_a), 32'h09);
    check("drop in WAIT_TX idle", 32'(busy), 32'd0);
    run_frame('{8'h01, 8'h01, 8'h20, 6'h20, 8'h02});

    // rx in the same cycle as WAIT_TX -> IDLE is dropped.
    @(negedge clk);
    tx_done_tick = 1'b1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h55;
    @(negedge clk);
    tx_done_tick = 1'b0;
    rx_done_tick = 1'b0;
    check("rx at transition busy", 32'(busy), 32'd0);
    check("rx at transition alu_a", 32'(alu_a), 32'h01);
    // Byte in the very next cycle is accepted as A.
    send_byte(8'h44);
    check("accept after idle busy", 32'(busy), 32'd1);
    check("accept after idle alu_a", 32'(alu_a), 32'h44);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset in WAIT_OP, coinciding with an rx tick: reset wins.
    send_byte(8'h11);
    send_byte(8'h22);
    c0 = tx_cnt;
    @(negedge clk);
    reset        = 1'b1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h20;
    @(negedge clk);
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort alu_a", 32'(alu_a), 32'd0);
    check("abort alu_b", 32'(alu_b), 32'd0);
    check("abort alu_op", 32'(alu_op), 32'd0);
    repeat (4) @(negedge clk);
    check("abort no tx_start", 32'(tx_cnt - c0), 32'd0);

    // Inter-byte gap.
    c0 = tx_cnt;
    send_byte(8'h05);
    repeat (18) @(negedge clk);
`ifdef IFACE_TIMEOUT_EN
    check("timeout returns idle", 32'(busy), 32'd0);
    check("timeout keeps alu_a", 32'(alu_a), 32'h05);
`else
    check("no timeout stays busy", 32'(busy), 32'd1);
    send_byte(8'h06);
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    check("late frame tx_data", 32'(tx_data), 32'h0B);
    pulse_tx_done();
    c0 = c0 + 1;
`endif
    check("gap tx_start count", 32'(tx_cnt - c0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
